// File: rtl/sdram_test_pkg.sv
// sdram_test_pkg: state encoding and pattern defaults shared by the SDRAM test
// write-side sequencer and read-side checker so both agree on the data pattern.
package sdram_test_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, CHECK = 2'd1, DONE = 2'd2} state_t;
  localparam int DEF_DW         = 16;
  localparam int DEF_WORD_COUNT = 512;
  localparam int DEF_SEED       = 0;
endpackage

// File: rtl/sdram_rd_lat_pipe.sv
// sdram_rd_lat_pipe: RD_LATENCY-deep delay line of the read strobe; valid marks
// the cycle in which the FIFO read data belonging to a sampled strobe is present.
module sdram_rd_lat_pipe #(
  parameter int RD_LATENCY = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic rd,
  output logic valid
);
  logic [RD_LATENCY-1:0] pipe_q, pipe_d;
  always_comb begin
    pipe_d = '0;
    if (!flush) begin
      pipe_d[0] = rd;
      for (int i = 1; i < RD_LATENCY; i++) pipe_d[i] = pipe_q[i-1];
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) pipe_q <= '0;
    else     pipe_q <= pipe_d;
  assign valid = pipe_q[RD_LATENCY-1];
endmodule

// File: rtl/sdram_rd_check.sv
// sdram_rd_check: checks FIFO read data against a regenerated incrementing pattern.
// Optional watchdog enabled by defining SDRAM_RD_CHECK_TIMEOUT_EN.
module sdram_rd_check
  import sdram_test_pkg::*;
#(
  parameter int            DW          = DEF_DW,
  parameter int            WORD_COUNT  = DEF_WORD_COUNT,
  parameter int            CNT_W       = 10,
  parameter int            RD_LATENCY  = 1,
  parameter logic [DW-1:0] SEED        = DW'(DEF_SEED),
  parameter int            TIMEOUT_CYC = 65535
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sys_rd,
  input  logic [DW-1:0]    sys_data_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [DW-1:0]    first_err_data,
  output logic             timeout
);
  state_t           state_q, state_d;
  logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d, tmo_q, tmo_d;
  logic [CNT_W-1:0] err_q, err_d, fidx_q, fidx_d, idx_q, idx_d;
  logic [DW-1:0]    fdata_q, fdata_d, exp_q, exp_d;
  logic             valid, mism, last, tmo_hit;

  sdram_rd_lat_pipe #(.RD_LATENCY(RD_LATENCY)) u_pipe (
    .clk   (clk),
    .rst   (rst),
    .flush (start),
    .rd    (sys_rd && state_q == CHECK),
    .valid (valid)
  );

`ifdef SDRAM_RD_CHECK_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] wd_q, wd_d;
  assign wd_d    = (start || valid || state_q != CHECK) ? '0 : wd_q + TW'(1);
  assign tmo_hit = state_q == CHECK && !valid && wd_q == TW'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) wd_q <= '0;
    else     wd_q <= wd_d;
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    mism    = valid && sys_data_out != exp_q;
    last    = valid && idx_q == CNT_W'(WORD_COUNT - 1);
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    fidx_d  = fidx_q;
    fdata_d = fdata_q;
    idx_d   = idx_q;
    exp_d   = exp_q;
    if (start) begin
      state_d = CHECK;
      busy_d  = 1'b1;
      done_d  = 1'b0;
      pass_d  = 1'b0;
      tmo_d   = 1'b0;
      err_d   = '0;
      fidx_d  = '0;
      fdata_d = '0;
      idx_d   = '0;
      exp_d   = SEED;
    end else if (state_q == CHECK) begin
      if (mism && err_q == '0) begin
        fidx_d  = idx_q;
        fdata_d = sys_data_out;
      end
      if (mism && err_q != '1) err_d = err_q + CNT_W'(1);
      if (valid) begin
        idx_d = idx_q + CNT_W'(1);
        exp_d = exp_q + DW'(1);
      end
      // pass must include the compare of the final word, hence err_d
      if (last || tmo_hit) begin
        state_d = DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        pass_d  = !tmo_hit && err_d == '0;
        tmo_d   = tmo_hit;
      end
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      tmo_q   <= 1'b0;
      err_q   <= '0;
      fidx_q  <= '0;
      fdata_q <= '0;
      idx_q   <= '0;
      exp_q   <= SEED;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      fidx_q  <= fidx_d;
      fdata_q <= fdata_d;
      idx_q   <= idx_d;
      exp_q   <= exp_d;
    end

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_cnt        = err_q;
  assign first_err_idx  = fidx_q;
  assign first_err_data = fdata_q;
  assign timeout        = tmo_q;
endmodule

// File: tb/tb_sdram_rd_check.sv
// tb_sdram_rd_check: four checker configurations fed by a FIFO model with matching
// read latency; expected run results are queued at stimulus time and popped at done.
module tb_sdram_rd_check;
  localparam int LAT [4] = '{1, 3, 2, 1};
  localparam int WC  [4] = '{512, 512, 8, 16};
  localparam int CW  [4] = '{10, 10, 10, 4};
  localparam int SD  [4] = '{0, 0, 'hFFFE, 0};
  localparam int TO  [4] = '{100, 65535, 65535, 65535};
  localparam int MX  [4] = '{1023, 1023, 1023, 15};

  typedef struct packed {
    logic        pass;
    logic [9:0]  err;
    logic [9:0]  fi;
    logic [15:0] fd;
    logic        tmo;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_v [4];
  logic        rd_v    [4];
  logic [15:0] word_v  [4];
  logic        busy_v  [4];
  logic        done_v  [4];
  logic        pass_v  [4];
  logic        tmo_v   [4];
  logic [9:0]  err_v   [4];
  logic [9:0]  fi_v    [4];
  logic [15:0] fd_v    [4];
  res_t        sb [$];
  int          asserts = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    logic [CW[g]-1:0] ec, fi;
    logic [15:0]      dl [4];
    always @(posedge clk) begin
      dl[0] <= word_v[g];
      for (int j = 1; j < 4; j++) dl[j] <= dl[j-1];
    end
    sdram_rd_check #(
      .DW(16), .WORD_COUNT(WC[g]), .CNT_W(CW[g]), .RD_LATENCY(LAT[g]),
      .SEED(16'(SD[g])), .TIMEOUT_CYC(TO[g])
    ) u_dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start_v[g]),
      .sys_rd         (rd_v[g]),
      .sys_data_out   (dl[LAT[g]-1]),
      .busy           (busy_v[g]),
      .done           (done_v[g]),
      .pass           (pass_v[g]),
      .err_cnt        (ec),
      .first_err_idx  (fi),
      .first_err_data (fd_v[g]),
      .timeout        (tmo_v[g])
    );
    assign err_v[g] = 10'(ec);
    assign fi_v[g]  = 10'(fi);
  end

  function automatic res_t got(input int i);
    return '{pass: pass_v[i], err: err_v[i], fi: fi_v[i], fd: fd_v[i], tmo: tmo_v[i]};
  endfunction

  // Pulse start, then issue n reads; the FIFO model returns word k = SEED+k unless corrupted.
  task automatic drive(input int i, input int n, input int bad, input logic [15:0] bad_val,
                       input bit all_bad, input int gap, input bit push);
    res_t e;
    logic [15:0] x, d;
    e = '0;
    @(negedge clk); start_v[i] = 1'b1; rd_v[i] = 1'b0;
    @(negedge clk); start_v[i] = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (gap > 0) repeat ($urandom_range(0, gap)) @(negedge clk);
      x = 16'(SD[i] + k);
      d = all_bad ? ~x : (k == bad ? bad_val : x);
      if (d != x) begin
        if (e.err == 0) begin e.fi = 10'(k); e.fd = d; end
        if (int'(e.err) < MX[i]) e.err = e.err + 10'd1;
      end
      rd_v[i] = 1'b1; word_v[i] = d;
      @(negedge clk); rd_v[i] = 1'b0;
    end
    e.pass = e.err == 0;
    if (push) sb.push_back(e);
  endtask

  task automatic wait_done(input int i, output int c);
    c = 0;
    do begin @(posedge clk); #1; c++; end while (!done_v[i] && c < 50);
  endtask

  task automatic finish_run(input string name, input int i);
    int c;
    res_t e, r;
    wait_done(i, c);
    r = got(i);
    e = sb.pop_front();
    asserts++;
    if (r !== e) begin
      fails++;
      $display("FAIL %s result: got pass=%0d err=%0d fi=%0d fd=%h tmo=%0d, want pass=%0d err=%0d fi=%0d fd=%h tmo=%0d",
               name, r.pass, r.err, r.fi, r.fd, r.tmo, e.pass, e.err, e.fi, e.fd, e.tmo);
    end
    asserts++;
    if (c !== LAT[i]) begin
      fails++;
      $display("FAIL %s done_latency: got %0d cycles after last rd, want %0d", name, c, LAT[i]);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      asserts++;
      if ({busy_v[i], done_v[i], got(i)} !== '0) begin
        fails++;
        $display("FAIL reset_state[%0d]: got busy=%0d done=%0d res=%h, want all zero", i, busy_v[i], done_v[i], got(i));
      end
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_nominal();
    drive(0, 512, -1, 16'h0, 1'b0, 0, 1'b1);
    finish_run("nominal", 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); rd_v[0] = 1'b1; word_v[0] = 16'hDEAD;
    end
    @(negedge clk); rd_v[0] = 1'b0;
    repeat (3) @(negedge clk);
    asserts++;
    if ({done_v[0], pass_v[0], err_v[0]} !== {1'b1, 1'b1, 10'd0}) begin
      fails++;
      $display("FAIL overrun_ignored: got done=%0d pass=%0d err=%0d, want done=1 pass=1 err=0", done_v[0], pass_v[0], err_v[0]);
    end
  endtask

  task automatic test_single_error();
    drive(0, 512, 100, 16'h1234, 1'b0, 0, 1'b1);
    finish_run("single_error", 0);
  endtask

  task automatic test_gapped();
    drive(1, 512, -1, 16'h0, 1'b0, 3, 1'b1);
    finish_run("gapped_lat3", 1);
    drive(1, 512, 511, 16'h0000, 1'b0, 2, 1'b1);
    finish_run("gapped_last_word_bad", 1);
  endtask

  task automatic test_wrap();
    drive(2, 8, -1, 16'h0, 1'b0, 2, 1'b1);
    finish_run("seed_wrap", 2);
    drive(2, 8, 2, 16'h0001, 1'b0, 0, 1'b1);
    finish_run("seed_wrap_bad", 2);
  endtask

  task automatic test_saturation();
    drive(3, 16, -1, 16'h0, 1'b1, 0, 1'b1);
    finish_run("saturation", 3);
  endtask

  task automatic test_restart();
    drive(1, 300, 100, 16'h1234, 1'b0, 0, 1'b0);
    asserts++;
    if ({busy_v[1], done_v[1]} !== 2'b10) begin
      fails++;
      $display("FAIL restart_busy: got busy=%0d done=%0d, want busy=1 done=0", busy_v[1], done_v[1]);
    end
    // restart lands while words 298/299 are still in the latency pipe
    drive(1, 512, -1, 16'h0, 1'b0, 0, 1'b1);
    finish_run("restart", 1);
  endtask

  task automatic test_abort_reset();
    drive(0, 200, 100, 16'h1234, 1'b0, 0, 1'b0);
    #1 rst = 1'b1;
    #1;
    asserts++;
    if ({busy_v[0], done_v[0], got(0)} !== '0) begin
      fails++;
      $display("FAIL abort_reset: got busy=%0d done=%0d res=%h, want all zero", busy_v[0], done_v[0], got(0));
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    asserts++;
    if ({busy_v[0], done_v[0], got(0)} !== '0) begin
      fails++;
      $display("FAIL post_reset_idle: got busy=%0d done=%0d res=%h, want all zero", busy_v[0], done_v[0], got(0));
    end
  endtask

  task automatic test_timeout();
    drive(0, 10, -1, 16'h0, 1'b0, 0, 1'b0);
`ifdef SDRAM_RD_CHECK_TIMEOUT_EN
    repeat (100) @(posedge clk);
    #1;
    asserts++;
    if ({tmo_v[0], done_v[0]} !== 2'b00) begin
      fails++;
      $display("FAIL timeout_early: got tmo=%0d done=%0d, want 0 0", tmo_v[0], done_v[0]);
    end
    @(posedge clk); #1;
    asserts++;
    if ({tmo_v[0], done_v[0], pass_v[0], busy_v[0]} !== 4'b1100) begin
      fails++;
      $display("FAIL timeout_fire: got tmo=%0d done=%0d pass=%0d busy=%0d, want 1 1 0 0", tmo_v[0], done_v[0], pass_v[0], busy_v[0]);
    end
`else
    repeat (150) @(posedge clk);
    #1;
    asserts++;
    if ({busy_v[0], done_v[0], tmo_v[0]} !== 3'b100) begin
      fails++;
      $display("FAIL wait_forever: got busy=%0d done=%0d tmo=%0d, want 1 0 0", busy_v[0], done_v[0], tmo_v[0]);
    end
`endif
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      start_v[i] = 1'b0; rd_v[i] = 1'b0; word_v[i] = '0;
    end
    test_reset();
    test_nominal();
    test_single_error();
    test_gapped();
    test_wrap();
    test_saturation();
    test_restart();
    test_abort_reset();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
